// File: rtl/sa_output_collector.sv
// Drain side of the systolic array: de-skews the bottom-row wavefront into aligned rows and
// buffers them in a show-ahead FIFO. Define SA_COLLECT_RELU_EN to clamp negative words to 0 on write.

module sa_oc_lane #(
  parameter int ADD_BW = 32
) (
  input  logic [ADD_BW-1:0] i_word,
  output logic [ADD_BW-1:0] o_word
);
`ifdef SA_COLLECT_RELU_EN
  // Any word with the sign bit set, including negative zero, becomes +0.
  assign o_word = i_word[ADD_BW-1] ? '0 : i_word;
`else
  assign o_word = i_word;
`endif
endmodule

module sa_output_collector #(
  parameter int ADD_BW = 32,
  parameter int COLS   = 4,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_mode,
  input  logic                       i_valid,
  input  logic [COLS*ADD_BW-1:0]     i_bot,
  output logic [COLS*ADD_BW-1:0]     o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic                   w_start;
  logic [COLS-1:1]        r_vld_pipe;
  logic [COLS*ADD_BW-1:0] w_row;
  logic [COLS*ADD_BW-1:0] w_row_wr;

  assign w_start = i_valid & i_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= w_start;
      for (int k = 2; k < COLS; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
    end
  end

  // Stage k carries the k columns already sampled for the token that entered k cycles ago,
  // so every wavefront travels with its own partial row and overlapping rows never mix.
  for (genvar k = 1; k < COLS; k++) begin : g_stg
    logic [k*ADD_BW-1:0] r_part;
    if (k == 1) begin : g_first
      always_ff @(posedge clk) r_part <= i_bot[0 +: ADD_BW];
    end else begin : g_next
      always_ff @(posedge clk)
        r_part <= {i_bot[(k-1)*ADD_BW +: ADD_BW], g_stg[k-1].r_part};
    end
  end

  assign w_row = {i_bot[(COLS-1)*ADD_BW +: ADD_BW], g_stg[COLS-1].r_part};

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    sa_oc_lane #(.ADD_BW(ADD_BW)) u_lane (
      .i_word (w_row[c*ADD_BW +: ADD_BW]),
      .o_word (w_row_wr[c*ADD_BW +: ADD_BW])
    );
  end

  logic [COLS*ADD_BW-1:0] r_mem [DEPTH];
  logic [PW-1:0]          r_wr_ptr, r_rd_ptr, r_count;
  logic [PW-1:0]          w_wr_nxt, w_rd_nxt;
  logic                   r_ovf;
  logic                   w_empty, w_full, w_pop, w_push_req, w_push, w_drop;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop      = !w_empty && i_ready;
  assign w_push_req = r_vld_pipe[COLS-1];
  // A pop in the same cycle frees the head slot, so a full FIFO can still take the row.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_wr_nxt   = r_wr_ptr + PW'(w_push);
  assign w_rd_nxt   = r_rd_ptr + PW'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_wr_nxt - w_rd_nxt;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_row_wr;
  end

  assign o_valid    = !w_empty;
  assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_count    = r_count;
  assign o_overflow = r_ovf;
endmodule

// File: tb/tb_sa_output_collector.sv
// Bench for sa_output_collector: directed table, corner sequences and random traffic checked
// against a queue-based model of the collector.
module tb_sa_output_collector;
  localparam int AB    = 32;
  localparam int COLS  = 4;
  localparam int DEPTH = 8;
  localparam int W     = AB * COLS;
  localparam int MAXC  = 8192;

  logic         clk = 1'b0;
  logic         rst = 1'b0, i_mode = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
  logic [W-1:0] i_bot = '0;
  logic [W-1:0] o_data;
  logic         o_valid, o_overflow;
  logic [$clog2(DEPTH):0] o_count;

  sa_output_collector #(.ADD_BW(AB), .COLS(COLS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_valid(i_valid), .i_bot(i_bot),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int nvec = 0, nmis = 0, cyc = 0;
  logic [W-1:0] hist [MAXC];
  bit           started [MAXC];
  logic [W-1:0] q [$];
  bit           ovf = 1'b0;

  function automatic logic [AB-1:0] relu(input logic [AB-1:0] x);
`ifdef SA_COLLECT_RELU_EN
    return x[AB-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int j = 0; j < COLS; j++) r[j*AB +: AB] = $urandom;
    return r;
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s cyc=%0d got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // Drive one cycle from a negedge, advance the model across the edge, compare at the next negedge.
  task automatic cycle(input bit r, input bit m, input bit v, input bit rd, input logic [W-1:0] b);
    int t;
    logic [W-1:0] row;
    rst = r; i_mode = m; i_valid = v; i_ready = rd; i_bot = b;
    hist[cyc]    = b;
    started[cyc] = v && m && !r;
    if (r) begin
      q.delete();
      ovf = 1'b0;
      for (int k = 1; k < COLS; k++) if (cyc - k >= 0) started[cyc-k] = 1'b0;
    end else begin
      if (q.size() != 0 && rd) void'(q.pop_front());
      t = cyc - (COLS - 1);
      if (t >= 0 && started[t]) begin
        for (int j = 0; j < COLS; j++) row[j*AB +: AB] = relu(hist[t+j][j*AB +: AB]);
        if (q.size() < DEPTH) q.push_back(row);
        else ovf = 1'b1;
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
    check("valid", W'(o_valid), W'(q.size() != 0));
    check("count", W'(o_count), W'(q.size()));
    check("ovf",   W'(o_overflow), W'(ovf));
    check("data",  o_data, (q.size() != 0) ? q[0] : '0);
  endtask

  typedef struct {
    bit r, m, v, rd;
    logic [W-1:0] bot;
    bit e_vld;
    int e_cnt;
    logic [W-1:0] e_data;
  } vec_t;

  vec_t tbl [6];
  logic [W-1:0] exp_row;

  initial begin
    tbl[0] = '{1, 0, 0, 0, '0, 0, 0, '0};
    tbl[1] = '{0, 1, 1, 0, {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 32'h3F800000}, 0, 0, '0};
    tbl[2] = '{0, 1, 0, 0, {32'hBBBB0003, 32'hBBBB0002, 32'h3F800001, 32'hBBBB0000}, 0, 0, '0};
    tbl[3] = '{0, 1, 0, 0, {32'hCCCC0003, 32'h3F800002, 32'hCCCC0001, 32'hCCCC0000}, 0, 0, '0};
    tbl[4] = '{0, 1, 0, 0, {32'h3F800003, 32'hDDDD0002, 32'hDDDD0001, 32'hDDDD0000}, 1, 1,
               {32'h3F800003, 32'h3F800002, 32'h3F800001, 32'h3F800000}};
    tbl[5] = '{0, 1, 0, 1, '0, 0, 0, '0};

    @(negedge clk);
    // single row latency and alignment
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].r, tbl[i].m, tbl[i].v, tbl[i].rd, tbl[i].bot);
      check("tbl_valid", W'(o_valid), W'(tbl[i].e_vld));
      check("tbl_count", W'(o_count), W'(tbl[i].e_cnt));
      check("tbl_data",  o_data, tbl[i].e_data);
    end

    // fill, drop a 9th row, drain in order
    cycle(1, 0, 0, 0, '0);
    for (int i = 0; i < 9; i++) cycle(0, 1, 1, 0, rnd());
    cycle(0, 1, 0, 0, rnd());
    cycle(0, 1, 0, 0, rnd());
    check("full_count", W'(o_count), W'(8));
    check("full_ovf",   W'(o_overflow), W'(0));
    cycle(0, 1, 0, 0, rnd());
    check("drop_count", W'(o_count), W'(8));
    check("drop_ovf",   W'(o_overflow), W'(1));
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, 1, rnd());
    check("drained", W'(o_count), W'(0));
    check("ovf_sticky", W'(o_overflow), W'(1));

    // full FIFO: push coincides with pop
    cycle(1, 0, 0, 0, '0);
    for (int i = 0; i < 9; i++) cycle(0, 1, 1, 0, rnd());
    cycle(0, 1, 0, 0, rnd());
    cycle(0, 1, 0, 0, rnd());
    cycle(0, 1, 0, 1, rnd());
    check("pp_count", W'(o_count), W'(8));
    check("pp_ovf",   W'(o_overflow), W'(0));
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, 1, rnd());

    // weight-load mode ignores i_valid
    cycle(1, 0, 0, 0, '0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0, rnd());
    check("wl_valid", W'(o_valid), W'(0));
    check("wl_count", W'(o_count), W'(0));

    // reset while a row is in flight, with rows already buffered
    cycle(0, 1, 1, 0, rnd());
    cycle(0, 1, 1, 0, rnd());
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, rnd());
    check("pre_rst_count", W'(o_count), W'(2));
    cycle(0, 1, 1, 0, rnd());
    cycle(0, 1, 0, 0, rnd());
    cycle(1, 1, 0, 0, rnd());
    check("rst_valid", W'(o_valid), W'(0));
    check("rst_count", W'(o_count), W'(0));
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 1, rnd());
    check("abort_valid", W'(o_valid), W'(0));

    // sign handling
    cycle(0, 1, 1, 0, {32'h0, 32'h0, 32'h0, 32'hC0000000});
    cycle(0, 1, 0, 0, {32'h0, 32'h0, 32'h40000000, 32'h0});
    cycle(0, 1, 0, 0, {32'h0, 32'h80000000, 32'h0, 32'h0});
    cycle(0, 1, 0, 0, {32'h12345678, 32'h0, 32'h0, 32'h0});
`ifdef SA_COLLECT_RELU_EN
    exp_row = {32'h12345678, 32'h00000000, 32'h40000000, 32'h00000000};
`else
    exp_row = {32'h12345678, 32'h80000000, 32'h40000000, 32'hC0000000};
`endif
    check("sign_data", o_data, exp_row);
    cycle(0, 1, 0, 1, '0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0), rnd());

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
